// File: rtl/mem_route_pkg.sv
// Shared types and default sizing for the memory data router.
package mem_route_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NCH    = 2;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/route_slot.sv
// One-entry output slot: holds a word until the consumer takes it, and
// accepts a replacement word on the same cycle it is drained.
module route_slot
    import mem_route_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              free,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = FULL;
            data_d  = in_data;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    // Data is reset too so the output is never X while the slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign free      = (state_q == EMPTY) || out_ready;
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/mem_data_router.sv
// Routes each accepted word to one output slot (unicast) or all slots
// (broadcast); words addressed to a nonexistent channel are dropped and counted.
module mem_data_router
    import mem_route_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  NCH    = DEF_NCH,
    parameter int  CNT_W  = DEF_CNT_W,
    localparam int SEL_W  = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic                  err,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NCH-1:0]   free;
    logic [NCH-1:0]   load;
    logic             sel_legal;
    logic             sel_free;
    logic             xfer;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign sel_legal = int'(in_sel) < NCH;

    // Mux is written as a loop so an out-of-range in_sel never indexes free.
    always_comb begin
        sel_free = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (in_sel == SEL_W'(k)) sel_free = free[k];
        end
    end

    assign in_ready = in_bcast  ? &free :
                      sel_legal ? sel_free : 1'b1;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < NCH; k++) begin
            load[k] = xfer && (in_bcast || (sel_legal && in_sel == SEL_W'(k)));
        end
    end

    always_comb begin
        err_d     = xfer && !in_bcast && !sel_legal;
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        route_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .in_data   (in_data),
            .out_ready (out_ready[k]),
            .free      (free[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/mem_data_router.md
MEM_DATA_ROUTER -- requirements
Module: mem_data_router

Interface
REQ-001 Parameter DATA_W, default 16, sets the data word width in bits.
REQ-002 Parameter NCH, default 2, sets the number of output channels; legal range is 2..8.
REQ-003 Parameter CNT_W, default 8, sets the error counter width.
REQ-004 Derived constant SEL_W = max(1, clog2(NCH)).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  source offers a word.
REQ-008 in_ready  output  1  router accepts the word this cycle.
REQ-009 in_data  input  DATA_W  offered word.
REQ-010 in_sel  input  SEL_W  destination channel index.
REQ-011 in_bcast  input  1  deliver to all channels; in_sel ignored.
REQ-012 out_valid  output  NCH  per-channel word available.
REQ-013 out_ready  input  NCH  per-channel consumer takes the word.
REQ-014 out_data  output  NCH*DATA_W  per-channel word; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-015 err  output  1  one-cycle pulse on accepting a word with illegal in_sel.
REQ-016 err_cnt  output  CNT_W  saturating count of illegal-select words.

Function
REQ-017 A transfer occurs on any cycle where valid and ready are both high; there is no other acceptance condition.
REQ-018 Each channel has a one-entry slot with states EMPTY and FULL; out_valid[k] = (slot k == FULL).
REQ-019 Slot transitions: EMPTY->FULL on load; FULL->EMPTY on drain without load; FULL->FULL on drain with simultaneous load (new word replaces old, no bubble).
REQ-020 Slot k is free when it is EMPTY, or when it is FULL and out_ready[k] is high (same-cycle drain).
REQ-021 Unicast with in_sel < NCH: in_ready equals free(in_sel); on transfer, in_data loads only slot in_sel.
REQ-022 Broadcast: in_ready is the AND of free(k) over all k; on transfer, every slot loads in_data.
REQ-023 Unicast with in_sel >= NCH: in_ready is 1; the word is discarded, err pulses high the next cycle, and err_cnt increments, holding at 2^CNT_W-1.
REQ-024 Latency is one cycle from input transfer to out_valid; throughput is one word per cycle per channel.
REQ-025 out_data[k] holds its value while slot k is FULL and out_ready[k] is low; its value while EMPTY is don't-care but is never X after reset.
REQ-026 in_ready is combinational from slot state, out_ready, in_sel and in_bcast only, never from in_valid.
REQ-027 Channels drain independently; a stalled channel never blocks unicast traffic to other channels.

Reset
REQ-028 While rst_n is low: all slots EMPTY, out_valid = 0, out_data = 0, err = 0, err_cnt = 0.
REQ-029 An assertion of rst_n mid-transfer discards all slot contents; no partial word survives.
REQ-030 Reset deassertion is synchronised to clk by the parent; the first transfer is accepted on the first rising edge with rst_n high.

Structure
REQ-031 Shared package mem_route_pkg holds the slot-state enumeration (EMPTY, FULL) and the default DATA_W/NCH constants.
REQ-032 Per-channel storage is one sub-module, route_slot (one-entry register plus EMPTY/FULL state), instantiated NCH times by a generate loop.
REQ-033 The error counter stays in the top module.

Verification
REQ-034 NCH=2, unicast 0xA5A5 to sel 0 with out_ready=2'b01 -> out_valid=2'b01 one cycle later; word consumed; channel 1 untouched.
REQ-035 Hold out_ready[1]=0, send 0x1111 then 0x2222 to sel 1 -> second word waits with in_ready=0 until out_ready[1]=1; both words delivered in order.
REQ-036 Slot 0 FULL, out_ready[0]=1, new word 0x3333 to sel 0 on the same cycle -> accepted; next cycle out_data[0]=0x3333, out_valid[0] stays 1.
REQ-037 Broadcast 0xBEEF with slot 1 FULL and stalled -> in_ready=0; after out_ready[1]=1 both channels receive 0xBEEF together.
REQ-038 NCH=3, in_sel=3 sent 260 times with CNT_W=8 -> err pulses each time; err_cnt saturates at 255; no out_valid change.
REQ-039 Assert rst_n low while both slots are FULL -> out_valid=0 and err_cnt=0 immediately, without waiting for a clock edge.
